// File: rtl/hazard_unit_8051.sv
// Pipeline interlock for the 8051 core: load-use stalls on ACC, MUL/DIV occupancy of EX, taken-branch flushes.
// Define HAZARD_MULDIV_EN to enable the multi-cycle MUL/DIV interlock (MULDIV state and occupancy counter).
module hazard_unit_8051 #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ID_uses_acc,
  input  logic        ID_ex_acc_write,
  input  logic        ID_ex_mem_read,
  input  logic        EX_muldiv_start,
  input  logic        EX_muldiv_is_div,
  input  logic        EX_branch_taken,
  output logic        stall_if,
  output logic        stall_id,
  output logic        bubble_ex,
  output logic        ex_hold,
  output logic        flush_if_id,
  output logic        busy,
  output logic [1:0]  state,
  output logic [15:0] stall_cycles
);

  // Handshake: there is none; every control is a same-cycle level derived from
  // the registered state and the current inputs, and is consumed by the
  // pipeline-register enables on the next rising edge.

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_UNUSED = 2'b01,
    ST_MULDIV = 2'b10,
    ST_FLUSH  = 2'b11
  } state_t;

  state_t state_q, state_d;
  logic   load_use;

  assign load_use = ID_ex_mem_read & ID_ex_acc_write & ID_uses_acc;
  assign state    = state_q;
  assign busy     = (state_q != ST_RUN);

`ifdef HAZARD_MULDIV_EN
  localparam int unsigned MAX_N = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W = $clog2(MAX_N);
  // The start cycle and the final counter==0 cycle both count toward N.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_muldiv;
  assign unused_muldiv = ^{EX_muldiv_start, EX_muldiv_is_div, 32'(MUL_CYCLES), 32'(DIV_CYCLES)};
`endif

  always_comb begin
    state_d     = ST_RUN;
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    bubble_ex   = 1'b0;
    ex_hold     = 1'b0;
    flush_if_id = 1'b0;
`ifdef HAZARD_MULDIV_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
`ifdef HAZARD_MULDIV_EN
      ST_MULDIV: begin
        // Branch and load-use are masked while EX is occupied.
        stall_if = 1'b1;
        stall_id = 1'b1;
        ex_hold  = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_MULDIV;
          cnt_d   = cnt_q - 1'b1;
        end
      end
`endif
      ST_FLUSH: begin
        // ID holds the NOP just inserted, so load-use cannot fire here.
        flush_if_id = 1'b1;
        state_d     = ST_RUN;
      end
      default: begin
        // RUN, the unused encoding, and MULDIV when the feature is compiled out.
        if (EX_branch_taken) begin
          flush_if_id = 1'b1;
          bubble_ex   = 1'b1;
          state_d     = ST_FLUSH;
        end
`ifdef HAZARD_MULDIV_EN
        else if (EX_muldiv_start) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          ex_hold  = 1'b1;
          cnt_d    = EX_muldiv_is_div ? DIV_LOAD : MUL_LOAD;
          state_d  = ST_MULDIV;
        end
`endif
        else if (load_use) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      stall_cycles <= 16'h0000;
`ifdef HAZARD_MULDIV_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef HAZARD_MULDIV_EN
      cnt_q   <= cnt_d;
`endif
      if (stall_if && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit_8051.sv
// Self-checking bench for hazard_unit_8051; covers both builds of HAZARD_MULDIV_EN.
module tb_hazard_unit_8051;

  localparam int MUL_N = 4;
  localparam int DIV_N = 8;
`ifdef HAZARD_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        ID_uses_acc = 1'b0, ID_ex_acc_write = 1'b0, ID_ex_mem_read = 1'b0;
  logic        EX_muldiv_start = 1'b0, EX_muldiv_is_div = 1'b0, EX_branch_taken = 1'b0;
  logic        stall_if, stall_id, bubble_ex, ex_hold, flush_if_id, busy;
  logic [1:0]  state;
  logic [15:0] stall_cycles;

  hazard_unit_8051 #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .rst(rst),
    .ID_uses_acc(ID_uses_acc), .ID_ex_acc_write(ID_ex_acc_write), .ID_ex_mem_read(ID_ex_mem_read),
    .EX_muldiv_start(EX_muldiv_start), .EX_muldiv_is_div(EX_muldiv_is_div),
    .EX_branch_taken(EX_branch_taken),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex), .ex_hold(ex_hold),
    .flush_if_id(flush_if_id), .busy(busy), .state(state), .stall_cycles(stall_cycles)
  );

  // scoreboard: {state[1:0], busy, stall_if, stall_id, bubble_ex, ex_hold, flush_if_id}
  logic [7:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // reference model
  logic [1:0]  m_state = 2'b00;
  int          m_left  = 0;   // MULDIV cycles still to run, including the current one
  logic [15:0] m_stalls = 16'h0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] dut_vec();
    return {state, busy, stall_if, stall_id, bubble_ex, ex_hold, flush_if_id};
  endfunction

  // One clock cycle: drive, predict, compare at negedge, advance model at posedge.
  task automatic step(input string tag, input logic br, input logic ms, input logic dv,
                      input logic lu_use, input logic lu_wr, input logic lu_mr);
    logic si, sd, bb, hd, fl;
    logic [1:0] nxt;
    int nleft;
    EX_branch_taken  = br;
    EX_muldiv_start  = ms;
    EX_muldiv_is_div = dv;
    ID_uses_acc      = lu_use;
    ID_ex_acc_write  = lu_wr;
    ID_ex_mem_read   = lu_mr;
    if (br && ms) $display("note: illegal branch+muldiv encoding driven at %0t", $time);
    {si, sd, bb, hd, fl} = 5'b0;
    nxt   = 2'b00;
    nleft = m_left;
    case (m_state)
      2'b10: begin
        si = 1'b1; sd = 1'b1; hd = 1'b1;
        nleft = m_left - 1;
        nxt = (nleft == 0) ? 2'b00 : 2'b10;
      end
      2'b11: fl = 1'b1;
      default: begin
        if (br) begin
          fl = 1'b1; bb = 1'b1; nxt = 2'b11;
        end else if (MD_EN && ms) begin
          si = 1'b1; sd = 1'b1; hd = 1'b1;
          nleft = (dv ? DIV_N : MUL_N) - 1;
          nxt = 2'b10;
        end else if (lu_use && lu_wr && lu_mr) begin
          si = 1'b1; sd = 1'b1; bb = 1'b1;
        end
      end
    endcase
    exp_q.push_back({m_state, (m_state != 2'b00), si, sd, bb, hd, fl});
    @(negedge clk);
    check({tag, "/ctrl"}, 32'(dut_vec()), 32'(exp_q.pop_front()));
    check({tag, "/stall_cycles"}, 32'(stall_cycles), 32'(m_stalls));
    @(posedge clk);
    if (si && m_stalls != 16'hFFFF) m_stalls = m_stalls + 16'd1;
    m_state = nxt;
    m_left  = nleft;
    #1;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset applied mid-cycle; effect must be visible before any edge.
  task automatic apply_reset(input string tag);
    {EX_branch_taken, EX_muldiv_start, EX_muldiv_is_div} = 3'b0;
    {ID_uses_acc, ID_ex_acc_write, ID_ex_mem_read} = 3'b0;
    rst = 1'b1;
    #1;
    m_state = 2'b00; m_left = 0; m_stalls = 16'h0000;
    exp_q.push_back(8'h00);
    check({tag, "/ctrl"}, 32'(dut_vec()), 32'(exp_q.pop_front()));
    check({tag, "/stall_cycles"}, 32'(stall_cycles), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    exp_q.push_back(8'h00);
    check("por/ctrl", 32'(dut_vec()), 32'(exp_q.pop_front()));
    check("por/stall_cycles", 32'(stall_cycles), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // load-use: single-cycle stall, then clear
    step("lu", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle("lu_after", 2);
    // partial load-use conditions must not stall
    step("lu_nomem", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step("lu_nowr",  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step("lu_nouse", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // MUL
    step("mul", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("mul_run", MUL_N);

    // DIV with a branch pulsed in cycle 3 and a load-use in cycle 5
    step("div", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle("div_run", 1);
    step("div_br", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("div_run", 1);
    step("div_lu", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle("div_tail", DIV_N);

    // branch with coincident load-use
    step("br_lu", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step("flush_lu", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle("br_after", 2);

    // illegal branch+muldiv: branch wins
    step("br_md", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle("br_md_after", 3);

    // back-to-back MUL starts and random traffic
    step("mul2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      step("rand", ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    idle("drain", DIV_N + 2);

    // reset mid-MULDIV (counter=3) or mid-FLUSH
    if (MD_EN) begin
      step("rst_div", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      idle("rst_div_run", 3);
      apply_reset("rst_muldiv");
    end else begin
      step("rst_br", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      apply_reset("rst_flush");
    end
    idle("post_rst", 2);
    step("post_rst_lu", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

    // saturation: 65540 consecutive load-use stalls
    ID_uses_acc = 1'b1; ID_ex_acc_write = 1'b1; ID_ex_mem_read = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    m_stalls = 16'hFFFF;
    step("sat_lu", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step("sat_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_reset("rst_sat");

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
